// File: rtl/sa_pkg.sv
// Shared systolic-array definitions: controller state type and default array geometry.
package sa_pkg;

  localparam int SA_ROWS      = 8;
  localparam int SA_COLS      = 8;
  localparam int SA_DATAWIDTH = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_W = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } sa_state_t;

endpackage

// File: rtl/sa_valid_skew.sv
// Valid skew line: stage 0 is the live input, stages 1..DEPTH-1 are registered delays.
module sa_valid_skew #(
  parameter int DEPTH = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             din,
  output logic [DEPTH-1:0] stages,
  output logic             pending
);

  logic [DEPTH-1:1] sr;

  assign stages  = {sr, din};
  assign pending = |sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
    end else if (clr) begin
      sr <= '0;
    end else begin
      sr <= stages[DEPTH-2:0];
    end
  end

endmodule

// File: rtl/sa_ctrl.sv
// Systolic-array job controller: weight-row loading, skewed activation valids, drain and completion.
// Optional cycle counter enabled by defining SA_CTRL_PERF_EN.
module sa_ctrl
  import sa_pkg::*;
#(
  parameter int ROWS   = SA_ROWS,
  parameter int COLS   = SA_COLS,
  parameter int NVEC_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [NVEC_W-1:0] n_vec,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic              a_valid,
  output logic              a_ready,
  output logic [ROWS-1:0]   wt_en,
  output logic [ROWS-1:0]   row_valid,
  output logic [COLS-1:0]   col_valid,
  output logic              busy,
  output logic              done,
  output logic [31:0]       perf_cycles
);

  localparam int DEPTH = ROWS + COLS - 1;
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  sa_state_t         state;
  logic [ROW_W-1:0]  row_cnt;
  logic [NVEC_W-1:0] vec_cnt;
  logic [NVEC_W-1:0] n_vec_q;
  logic [DEPTH-1:0]  stages;
  logic              pending;
  logic              a_beat;
  logic              start_ok;

  assign w_ready  = (state == LOAD_W);
  assign a_ready  = (state == STREAM);
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);
  assign a_beat   = a_valid && a_ready;
  assign start_ok = (state == IDLE) && start && !abort;

  always_comb begin
    wt_en = '0;
    if (w_valid && w_ready) wt_en[row_cnt] = 1'b1;
  end

  sa_valid_skew #(.DEPTH(DEPTH)) u_skew (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (abort),
    .din     (a_beat),
    .stages  (stages),
    .pending (pending)
  );

  assign row_valid = stages[ROWS-1:0];
  assign col_valid = stages[ROWS-1 +: COLS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      row_cnt <= '0;
      vec_cnt <= '0;
      n_vec_q <= '0;
    end else if (abort) begin
      state   <= IDLE;
      row_cnt <= '0;
      vec_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state   <= LOAD_W;
            n_vec_q <= n_vec;
            row_cnt <= '0;
            vec_cnt <= '0;
          end
        end
        LOAD_W: begin
          if (w_valid) begin
            if (row_cnt == ROW_W'(ROWS - 1)) begin
              row_cnt <= '0;
              state   <= (n_vec_q == '0) ? DRAIN : STREAM;
            end else begin
              row_cnt <= row_cnt + ROW_W'(1);
            end
          end
        end
        STREAM: begin
          if (a_valid) begin
            vec_cnt <= vec_cnt + NVEC_W'(1);
            if (vec_cnt + NVEC_W'(1) == n_vec_q) state <= DRAIN;
          end
        end
        // Stage 0 is idle here, so only the registered stages decide completion.
        DRAIN: begin
          if (!pending) state <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef SA_CTRL_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_q <= '0;
    end else if (start_ok) begin
      perf_q <= '0;
    end else if (busy) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_cycles = perf_q;
`else
  logic unused_start_ok;
  assign unused_start_ok = start_ok;
  assign perf_cycles     = '0;
`endif

endmodule

// File: doc/sa_ctrl.md
SA_CTRL -- requirements
Module: sa_ctrl

Interface
REQ-001 SHALL have parameter ROWS, default 8: systolic array rows, one weight row per PE row.
REQ-002 SHALL have parameter COLS, default 8: systolic array columns.
REQ-003 SHALL have parameter NVEC_W, default 16: width of the activation-vector count.
REQ-004 SHALL have port clk, input, 1: single clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have port start, input, 1: job request, sampled in IDLE only.
REQ-007 SHALL have port abort, input, 1: cancel the current job.
REQ-008 SHALL have port n_vec, input, NVEC_W: activation vectors in the job, latched on accepted start.
REQ-009 SHALL have port w_valid / w_ready, input / output, 1 each: weight-row handshake.
REQ-010 SHALL have port a_valid / a_ready, input / output, 1 each: activation-vector handshake.
REQ-011 SHALL have port wt_en, output, ROWS: one-hot PE-row weight load enable.
REQ-012 SHALL have port row_valid, output, ROWS: skewed valid_in, one bit per PE row.
REQ-013 SHALL have port col_valid, output, COLS: bottom-edge result-capture strobe, one bit per column.
REQ-014 SHALL have port busy / done, output, 1 each: job in progress / one-cycle completion pulse.
REQ-015 SHALL have port perf_cycles, output, 32: job cycle count (see Configuration).

Function
REQ-016 FSM SHALL have states IDLE, LOAD_W, STREAM, DRAIN, DONE.
REQ-017 IDLE->LOAD_W SHALL occur on start=1 while abort=0; n_vec is latched; row counter is cleared.
REQ-018 LOAD_W: w_ready=1; each w_valid&&w_ready beat SHALL assert wt_en[row_cnt] in that same cycle, then increment row_cnt.
REQ-019 The beat with row_cnt=ROWS-1 SHALL go to STREAM, or to DRAIN if the latched n_vec=0.
REQ-020 STREAM: a_ready=1; each a_valid&&a_ready beat SHALL push 1 into a valid shift register of depth ROWS+COLS-1; a cycle with no beat SHALL push 0.
REQ-021 row_valid[i] SHALL equal shift stage i, with stage 0 equal to the accepted beat in that same cycle, so row i lags row 0 by i cycles.
REQ-022 col_valid[j] SHALL equal shift stage ROWS-1+j.
REQ-023 The beat that makes the accepted count equal n_vec SHALL go to DRAIN; a_ready SHALL be 0 outside STREAM.
REQ-024 DRAIN SHALL push 0 each cycle and go to DONE when all shift stages are 0.
REQ-025 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-026 busy SHALL be 1 in every state except IDLE.
REQ-027 start SHALL be ignored outside IDLE.
REQ-028 abort=1 in any state SHALL, at the next edge, clear the shift register, counters and wt_en, and go to IDLE with no done pulse.
REQ-029 When abort and start are both 1 in IDLE, abort SHALL win.
REQ-030 wt_en SHALL be all-zero outside accepted LOAD_W beats; w_valid stalls SHALL hold row_cnt.

Reset
REQ-031 While rst_n=0, state SHALL be IDLE and all outputs SHALL be 0, including wt_en, row_valid, col_valid, w_ready, a_ready, busy, done and perf_cycles.
REQ-032 Reset mid-job SHALL discard the job; no done pulse SHALL follow release.

Configuration
REQ-033 The macro SA_CTRL_PERF_EN SHALL select the performance counter.
REQ-034 With SA_CTRL_PERF_EN defined, perf_cycles SHALL clear on accepted start, increment every busy cycle, and hold after DONE until the next start.
REQ-035 Without SA_CTRL_PERF_EN, perf_cycles SHALL be tied to 0 and no counter flops SHALL be inferred.

Structure
REQ-036 Package sa_pkg SHALL hold the state enum sa_state_t and the default ROWS/COLS/DATAWIDTH constants shared with the PE array.
REQ-037 The valid skew shift register SHALL be sub-module sa_valid_skew, parameterised by depth.

Verification
REQ-038 ROWS=COLS=4, n_vec=3, no stalls -> wt_en 0001,0010,0100,1000 on cycles 1-4; row_valid[3] high 3 cycles after row_valid[0]; done exactly once; perf_cycles=15.
REQ-039 w_valid low on alternate LOAD_W cycles -> wt_en fires only on accepted beats; row order preserved; exactly 4 loads.
REQ-040 n_vec=0 -> LOAD_W, then DRAIN, then DONE; row_valid and col_valid stay 0.
REQ-041 abort during STREAM after 1 of 3 vectors -> IDLE next cycle; all valids 0; no done pulse.
REQ-042 start held high through DONE -> a second job begins only from IDLE; start while busy is ignored.
REQ-043 rst_n pulsed low in DRAIN -> all outputs 0 asynchronously; IDLE after release.
